// File: rtl/flash_arb_pkg.sv
// ============================================================================
//  Module   : flash_arb_pkg
//  Purpose  : Shared types and constants for the QSPI flash OBI arbiter.
//             Defines the 1-bit master ID, the master ID constants, the
//             arbitration policy encodings and width helpers for the ID FIFO.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_arb_pkg;

  // Identifies which master issued a transaction.
  typedef logic mst_id_t;

  localparam mst_id_t MST_IFETCH = 1'b0;  // core instruction fetch (XIP)
  localparam mst_id_t MST_DATA   = 1'b1;  // data / debug / register path

  // Arbitration policy encodings for PRIO_MODE.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Read/write pointer width; a depth-1 FIFO still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width, able to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_arb_id_fifo.sv
// ============================================================================
//  Module   : flash_arb_id_fifo
//  Purpose  : In-order FIFO of master IDs. One entry is pushed per granted
//             slave transaction and popped per slave response, so the head
//             always names the master owed the next response.
//  Ports    : clk_i  - clock
//             rst_ni - synchronous active-low reset (empties the FIFO)
//             push   - write din (ignored when full)
//             pop    - drop head entry (ignored when empty)
//             din    - master ID to store
//             dout   - master ID at the head
//             empty  - no entries stored
//             full   - DEPTH entries stored
//             count  - current occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_arb_id_fifo
  import flash_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  mst_id_t          din,
  output mst_id_t          dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  mst_id_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/flash_obi_arbiter.sv
// ============================================================================
//  Module   : flash_obi_arbiter
//  Purpose  : Two-master OBI arbiter in front of the QSPI flash controller
//             slave port. Master 0 is instruction fetch, master 1 is the
//             data/debug path. Pipelined transactions are supported; an
//             in-order ID FIFO routes each response to its issuing master.
//  Params   : PRIO_MODE - 0 round-robin, 1 fixed priority (m0 wins)
//             MAX_OUTST - granted-but-unanswered transaction limit (1..8)
//  Ports    : clk_i, rst_ni          - clock, synchronous active-low reset
//             m0_* / m1_*            - OBI manager-side ports of each master
//                                      (req/we/be/addr/data in, gnt/rvalid/
//                                      data out)
//             s_*                    - OBI port towards the flash controller
//             err_o                  - sticky: response with nothing pending
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_obi_arbiter
  import flash_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0: instruction fetch
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_data_o,
  // master 1: data / debug
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_data_o,
  // slave: flash controller
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_data_i,
  output logic        err_o
);

  localparam int CNT_W = cnt_width(MAX_OUTST);

  mst_id_t          sel;
  mst_id_t          hold_id;
  mst_id_t          rr_ptr;
  mst_id_t          fifo_head;
  logic             hold_vld;
  logic             err_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic             handshake;
  logic             rsp_pop;
  logic [CNT_W-1:0] fifo_count_unused;

  // Master selection. A request already shown to the slave keeps its owner
  // until granted, so a held ID overrides any fresh arbitration.
  always_comb begin
    sel = rr_ptr;
    if (hold_vld) begin
      sel = hold_id;
    end else if (m0_req_i && !m1_req_i) begin
      sel = MST_IFETCH;
    end else if (m1_req_i && !m0_req_i) begin
      sel = MST_DATA;
    end else if (m0_req_i && m1_req_i && (PRIO_MODE == PRIO_FIXED)) begin
      sel = MST_IFETCH;
    end
  end

  // No full-bypass: a pop in the same cycle does not unmask a full FIFO.
  assign s_req_o   = rst_ni & (m0_req_i | m1_req_i | hold_vld) & ~fifo_full;
  assign handshake = s_req_o & s_gnt_i;

  assign s_we_o   = (sel == MST_DATA) ? m1_we_i   : m0_we_i;
  assign s_be_o   = (sel == MST_DATA) ? m1_be_i   : m0_be_i;
  assign s_addr_o = (sel == MST_DATA) ? m1_addr_i : m0_addr_i;
  assign s_data_o = (sel == MST_DATA) ? m1_data_i : m0_data_i;

  assign m0_gnt_o = handshake & (sel == MST_IFETCH);
  assign m1_gnt_o = handshake & (sel == MST_DATA);

  // A response with nothing outstanding is dropped and flagged instead.
  assign rsp_pop     = rst_ni & s_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = rsp_pop & (fifo_head == MST_IFETCH);
  assign m1_rvalid_o = rsp_pop & (fifo_head == MST_DATA);
  assign m0_data_o   = s_data_i;
  assign m1_data_o   = s_data_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_vld <= 1'b0;
      hold_id  <= MST_IFETCH;
      rr_ptr   <= MST_IFETCH;
      err_q    <= 1'b0;
    end else begin
      if (s_req_o && !s_gnt_i) begin
        hold_vld <= 1'b1;
        hold_id  <= sel;
      end else if (handshake) begin
        hold_vld <= 1'b0;
      end
      // The master just served loses preference to the other one.
      if (handshake && (PRIO_MODE == PRIO_RR)) begin
        rr_ptr <= ~sel;
      end
      if (s_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  flash_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (rsp_pop),
    .din    (sel),
    .dout   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count_unused)
  );

endmodule

`default_nettype wire
